// File: rtl/rr_arbiter8.sv
// Locking round-robin arbiter for 8 requesters with a hold timeout.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module rr_arbiter8 #(
  parameter int NUM_REQ = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               gnt_valid,
  output logic               timeout_pulse
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic               tp_q, tp_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [2:0]         ptr_q, ptr_d;
`endif

  logic [NUM_REQ-1:0] others;
  logic [2:0]         base;
  logic [2:0]         nxt;
  logic [3:0]         win;
  logic               hold_max;

  // {found, index} of the first set bit of m at or above b, wrapping.
  function automatic logic [3:0] pick(
    input logic [NUM_REQ-1:0] m,
    input logic [2:0]         b
  );
    logic [3:0] r;
    logic [2:0] j;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = b + 3'(i);
      if (m[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  // The owner's bit is excluded, so one search serves idle,
  // release (owner bit already low) and timeout alike.
  assign others   = req & ~gnt_q;
  assign nxt      = idx_q + 3'd1;
  assign hold_max = (hcnt_q == CNT_W'(TIMEOUT - 1));

`ifdef ARB_FIXED_PRIO_EN
  assign base = 3'd0;
`else
  assign base = (state_q == IDLE) ? ptr_q : nxt;
`endif

  assign win = pick(others, base);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    tp_d    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win[3]) begin
          state_d = OWNED;
          gnt_d   = NUM_REQ'(1) << win[2:0];
          idx_d   = win[2:0];
          hcnt_d  = '0;
        end
      end
      OWNED: begin
        if (!req[idx_q]) begin
`ifndef ARB_FIXED_PRIO_EN
          ptr_d  = nxt;
`endif
          hcnt_d = '0;
          if (win[3]) begin
            gnt_d = NUM_REQ'(1) << win[2:0];
            idx_d = win[2:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = 3'd0;
          end
        end else if (hold_max) begin
          // Lone owner past the limit keeps the grant, counter saturated.
          if (win[3]) begin
`ifndef ARB_FIXED_PRIO_EN
            ptr_d  = nxt;
`endif
            gnt_d  = NUM_REQ'(1) << win[2:0];
            idx_d  = win[2:0];
            hcnt_d = '0;
            tp_d   = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= 3'd0;
      hcnt_q  <= '0;
      tp_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
      tp_q    <= tp_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign gnt_idx       = idx_q;
  assign gnt_valid     = |gnt_q;
  assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random bench for rr_arbiter8 against an
// owner/pointer/held-cycles reference model.
module tb_rr_arbiter8;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_pulse;

  int vectors;
  int miscompares;

  int owner;
  int ptr;
  int held;
  bit exp_tp;

  rr_arbiter8 #(
    .NUM_REQ(8),
    .TIMEOUT(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int start_at(input int p);
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return p;
`endif
  endfunction

  function automatic int srch(input logic [7:0] m, input int from);
    for (int o = 0; o < 8; o++) begin
      if (m[(from + o) % 8]) return (from + o) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] g;
    g = 8'h00;
    if (owner >= 0) g[owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    owner  = -1;
    ptr    = 0;
    held   = 0;
    exp_tp = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] oth;
    int w;
    exp_tp = 1'b0;
    if (owner < 0) begin
      w = srch(r, start_at(ptr));
      if (w >= 0) begin
        owner = w;
        held  = 1;
      end
    end else if (!r[owner]) begin
      ptr   = (owner + 1) % 8;
      owner = srch(r, start_at(ptr));
      held  = (owner >= 0) ? 1 : 0;
    end else begin
      oth        = r;
      oth[owner] = 1'b0;
      if (held >= TO && oth != 8'h00) begin
        ptr    = (owner + 1) % 8;
        owner  = srch(oth, start_at(ptr));
        held   = 1;
        exp_tp = 1'b1;
      end else begin
        held++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt()));
    chk({tag, ".idx"}, 32'(gnt_idx), (owner < 0) ? 32'd0 : 32'(owner));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(owner >= 0));
    chk({tag, ".tp"}, 32'(timeout_pulse), 32'(exp_tp));
  endtask

  task automatic step(input logic [7:0] r, input string tag);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] r;
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.idx", 32'(gnt_idx), 32'h0);
    chk("rst.valid", 32'(gnt_valid), 32'h0);
    chk("rst.tp", 32'(timeout_pulse), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(8'hFF, "first");
    chk("first.const", 32'(gnt), 32'h01);

    step(8'h81, "rot.hold");
    step(8'h80, "rot.drop0");
    chk("rot.to7", 32'(gnt_idx), 32'd7);
    step(8'h01, "rot.wrap");
    chk("rot.wrap.const", 32'(gnt), 32'h01);
    step(8'h00, "rot.idle");

    step(8'h06, "to.first");
    chk("to.first.const", 32'(gnt), 32'h02);
    for (int i = 0; i < TO - 1; i++) begin
      step(8'h06, "to.hold");
      chk("to.hold.const", 32'(gnt), 32'h02);
    end
    step(8'h06, "to.switch");
    chk("to.switch.gnt", 32'(gnt), 32'h04);
    chk("to.switch.tp", 32'(timeout_pulse), 32'h1);
    step(8'h06, "to.after");
    chk("to.after.tp", 32'(timeout_pulse), 32'h0);
    step(8'h00, "to.idle");

    for (int i = 0; i < 40; i++) begin
      step(8'h20, "lone");
      chk("lone.gnt", 32'(gnt), 32'h20);
      chk("lone.tp", 32'(timeout_pulse), 32'h0);
    end

    step(8'h10, "ar.grant");
    chk("ar.grant.const", 32'(gnt), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.gnt", 32'(gnt), 32'h0);
    chk("ar.valid", 32'(gnt_valid), 32'h0);
    chk("ar.idx", 32'(gnt_idx), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    step(8'h0C, "fp.own2");
    step(8'h08, "fp.rel2");
    step(8'h04, "fp.back");
`ifdef ARB_FIXED_PRIO_EN
    chk("fp.back.const", 32'(gnt), 32'h04);
`endif
    step(8'h00, "fp.idle");

    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 12) begin
        r = 8'($urandom) & 8'($urandom);
      end
      step(r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
